// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment scan controller: active-low
// segment codes {a,b,c,d,e,f,g} (bit 6 = a) and the slot FSM state type.
package seg7_pkg;

  localparam int unsigned SEG_W = 7;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  localparam logic [SEG_W-1:0] SEG_HEX_0 = 7'b0000001;
  localparam logic [SEG_W-1:0] SEG_HEX_1 = 7'b1001111;
  localparam logic [SEG_W-1:0] SEG_HEX_2 = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_HEX_3 = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_HEX_4 = 7'b1001100;
  localparam logic [SEG_W-1:0] SEG_HEX_5 = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_HEX_6 = 7'b0100000;
  localparam logic [SEG_W-1:0] SEG_HEX_7 = 7'b0001111;
  localparam logic [SEG_W-1:0] SEG_HEX_8 = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_HEX_9 = 7'b0000100;
  localparam logic [SEG_W-1:0] SEG_HEX_A = 7'b0001000;
  localparam logic [SEG_W-1:0] SEG_HEX_B = 7'b1100000;
  localparam logic [SEG_W-1:0] SEG_HEX_C = 7'b0110001;
  localparam logic [SEG_W-1:0] SEG_HEX_D = 7'b1000010;
  localparam logic [SEG_W-1:0] SEG_HEX_E = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_HEX_F = 7'b0111000;

  // BLANK keeps anodes off at the start of every slot to avoid ghosting
  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } scan_state_e;

endpackage

// File: rtl/seg7_hex_dec.sv
// Combinational hex nibble to active-low seven-segment decoder.
module seg7_hex_dec
  import seg7_pkg::*;
(
  input  logic [3:0]       nibble,
  output logic [SEG_W-1:0] seg_c
);

  always_comb begin
    seg_c = SEG_BLANK;
    case (nibble)
      4'h0: seg_c = SEG_HEX_0;
      4'h1: seg_c = SEG_HEX_1;
      4'h2: seg_c = SEG_HEX_2;
      4'h3: seg_c = SEG_HEX_3;
      4'h4: seg_c = SEG_HEX_4;
      4'h5: seg_c = SEG_HEX_5;
      4'h6: seg_c = SEG_HEX_6;
      4'h7: seg_c = SEG_HEX_7;
      4'h8: seg_c = SEG_HEX_8;
      4'h9: seg_c = SEG_HEX_9;
      4'hA: seg_c = SEG_HEX_A;
      4'hB: seg_c = SEG_HEX_B;
      4'hC: seg_c = SEG_HEX_C;
      4'hD: seg_c = SEG_HEX_D;
      4'hE: seg_c = SEG_HEX_E;
      4'hF: seg_c = SEG_HEX_F;
    endcase
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed hex display scanner with tear-free, frame-aligned updates.
// Optional leading-zero suppression is enabled by defining SEG7_LZ_BLANK_EN.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [4*NUM_DIGITS-1:0] wr_data,
  output logic [SEG_W-1:0]        seg_n,
  output logic [NUM_DIGITS-1:0]   an_n
);

  localparam int unsigned TICK_W = $clog2(REFRESH_DIV);
  localparam int unsigned DIG_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned DATA_W = 4 * NUM_DIGITS;

  scan_state_e             state;
  scan_state_e             state_nxt;
  logic [TICK_W-1:0]       tick_cnt;
  logic [TICK_W-1:0]       tick_nxt;
  logic [DIG_W-1:0]        digit_idx;
  logic [DIG_W-1:0]        digit_nxt;
  logic [DATA_W-1:0]       disp_reg;
  logic [DATA_W-1:0]       disp_nxt;
  logic [DATA_W-1:0]       shadow_reg;
  logic [DATA_W-1:0]       shadow_nxt;
  logic                    pending;
  logic                    pending_nxt;
  logic [NUM_DIGITS-1:0]   an_nxt;
  logic [SEG_W-1:0]        seg_nxt;
  logic [3:0]              nibble_sel;
  logic [SEG_W-1:0]        dec_seg_c;
  logic                    lz_sup_c;
  logic                    tick_wrap_c;
  logic                    digit_last_c;
  logic                    frame_wrap_c;
  logic                    wr_fire_c;

  assign tick_wrap_c  = (tick_cnt == TICK_W'(REFRESH_DIV - 1));
  assign digit_last_c = (digit_idx == DIG_W'(NUM_DIGITS - 1));
  assign frame_wrap_c = tick_wrap_c && digit_last_c;
  assign wr_fire_c    = wr_valid && wr_ready;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_BLANK;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: slot timing, FSM, anode drive and shadow/display handoff
  always_comb begin
    tick_nxt    = tick_cnt + TICK_W'(1);
    digit_nxt   = digit_idx;
    state_nxt   = state;
    an_nxt      = '1;
    disp_nxt    = disp_reg;
    shadow_nxt  = shadow_reg;
    pending_nxt = pending;

    if (tick_wrap_c) begin
      tick_nxt  = '0;
      digit_nxt = digit_last_c ? '0 : digit_idx + DIG_W'(1);
    end

    case (state)
      ST_BLANK: if (tick_nxt == TICK_W'(BLANK_CYCLES)) state_nxt = ST_DRIVE;
      ST_DRIVE: if (tick_wrap_c) state_nxt = ST_BLANK;
    endcase

    if (state_nxt == ST_DRIVE && en) begin
      for (int k = 0; k < int'(NUM_DIGITS); k++) begin
        if (digit_nxt == DIG_W'(k)) an_nxt[k] = 1'b0;
      end
    end

    // A write taken on the boundary edge sees pending=0 here, so it waits a frame
    if (frame_wrap_c && pending) begin
      disp_nxt    = shadow_reg;
      pending_nxt = 1'b0;
    end else if (wr_fire_c) begin
      shadow_nxt  = wr_data;
      pending_nxt = 1'b1;
    end
  end

  // Nibble for the digit that will be on the anodes after this edge
  always_comb begin
    nibble_sel = 4'h0;
    for (int k = 0; k < int'(NUM_DIGITS); k++) begin
      if (digit_nxt == DIG_W'(k)) nibble_sel = disp_nxt[4*k +: 4];
    end
  end

`ifdef SEG7_LZ_BLANK_EN
  // Suppress when this and every higher nibble are zero; digit 0 always shows
  always_comb begin
    lz_sup_c = (digit_nxt != '0);
    for (int k = 0; k < int'(NUM_DIGITS); k++) begin
      if (DIG_W'(k) >= digit_nxt && disp_nxt[4*k +: 4] != 4'h0) lz_sup_c = 1'b0;
    end
  end
`else
  assign lz_sup_c = 1'b0;
`endif

  seg7_hex_dec u_dec (
    .nibble (nibble_sel),
    .seg_c  (dec_seg_c)
  );

  always_comb begin
    seg_nxt = SEG_BLANK;
    if (state_nxt == ST_DRIVE && !lz_sup_c) seg_nxt = dec_seg_c;
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt   <= '0;
      digit_idx  <= '0;
      disp_reg   <= '0;
      shadow_reg <= '0;
      pending    <= 1'b0;
      wr_ready   <= 1'b1;
      an_n       <= '1;
      seg_n      <= SEG_BLANK;
    end else begin
      tick_cnt   <= tick_nxt;
      digit_idx  <= digit_nxt;
      disp_reg   <= disp_nxt;
      shadow_reg <= shadow_nxt;
      pending    <= pending_nxt;
      wr_ready   <= ~pending_nxt;
      an_n       <= an_nxt;
      seg_n      <= seg_nxt;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl (4 digits, 8-cycle slots, 2 blank cycles).
// Honours SEG7_LZ_BLANK_EN when defined for the leading-zero expectations.
module tb_seg7_scan_ctrl;

  localparam int ND    = 4;
  localparam int RD    = 8;
  localparam int BC    = 2;
  localparam int FRAME = ND * RD;

  logic        clk      = 1'b0;
  logic        rst      = 1'b1;
  logic        en       = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [15:0] wr_data  = '0;
  logic [6:0]  seg_n;
  logic [3:0]  an_n;

  int          errors = 0;
  int          checks = 0;
  int          cyc    = 0;
  logic        en_edge = 1'b0;
  int          q_at[$];
  logic [15:0] q_dat[$];
  logic [3:0]  an_seq [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

  seg7_scan_ctrl #(
    .NUM_DIGITS   (ND),
    .REFRESH_DIV  (RD),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_data  (wr_data),
    .seg_n    (seg_n),
    .an_n     (an_n)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: return 7'b0000001;  4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;  4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;  4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;  4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;  4'h9: return 7'b0000100;
      4'hA: return 7'b0001000;  4'hB: return 7'b1100000;
      4'hC: return 7'b0110001;  4'hD: return 7'b1000010;
      4'hE: return 7'b0110000;  default: return 7'b0111000;
    endcase
  endfunction

  // Value on the display: the latest accepted write whose frame has started
  function automatic logic [15:0] shown_value();
    logic [15:0] v = '0;
    for (int i = 0; i < q_at.size(); i++) if (q_at[i] <= cyc) v = q_dat[i];
    return v;
  endfunction

  function automatic bit model_pending();
    return (q_at.size() > 0) && (q_at[q_at.size()-1] > cyc);
  endfunction

  task automatic chk_an(input string tag, input logic [3:0] exp);
    checks++;
    assert (an_n === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d an_n observed=%h expected=%h", tag, cyc, an_n, exp);
    end
  endtask

  task automatic chk_seg(input string tag, input logic [6:0] exp);
    checks++;
    assert (seg_n === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d seg_n observed=%b expected=%b", tag, cyc, seg_n, exp);
    end
  endtask

  task automatic chk_rdy(input string tag, input logic exp);
    checks++;
    assert (wr_ready === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d wr_ready observed=%b expected=%b", tag, cyc, wr_ready, exp);
    end
  endtask

  task automatic check_outputs();
    int          tick = cyc % RD;
    int          dig  = (cyc / RD) % ND;
    logic [15:0] v    = shown_value();
    logic [3:0]  ea   = 4'hF;
    logic [6:0]  es   = 7'h7F;
    if (tick >= BC) begin
      if (en_edge) ea[dig] = 1'b0;
      es = hex7(v[4*dig +: 4]);
`ifdef SEG7_LZ_BLANK_EN
      if (dig > 0 && (v >> (4*dig)) == 16'h0) es = 7'h7F;
`endif
    end
    chk_an("model_an", ea);
    chk_seg("model_seg", es);
    chk_rdy("model_rdy", !model_pending());
  endtask

  // One clock: drive at negedge, model the edge, check at the next negedge
  task automatic step(input logic v, input logic [15:0] d, input logic e);
    bit acc;
    wr_valid = v;
    wr_data  = d;
    en       = e;
    acc      = v && !model_pending();
    @(posedge clk);
    if (acc) begin
      q_at.push_back(((cyc + 1) / FRAME + 1) * FRAME);
      q_dat.push_back(d);
    end
    cyc++;
    en_edge = e;
    @(negedge clk);
    check_outputs();
  endtask

  task automatic go_to(input int k);
    int n = 0;
    while ((cyc % FRAME) != k && n < FRAME) begin
      step(1'b0, 16'($urandom), 1'b1);
      n++;
    end
  endtask

  task automatic write_word(input logic [15:0] d);
    int n = 0;
    while (model_pending() && n < 2*FRAME) begin
      step(1'b1, d, 1'b1);
      n++;
    end
    step(1'b1, d, 1'b1);
  endtask

  task automatic settle();
    int n = 0;
    while (model_pending() && n < 2*FRAME) begin
      step(1'b0, 16'($urandom), 1'b1);
      n++;
    end
  endtask

  task automatic pulse_reset();
    wr_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk_an("async_rst_an", 4'hF);
    chk_seg("async_rst_seg", 7'h7F);
    chk_rdy("async_rst_rdy", 1'b1);
    q_at.delete();
    q_dat.delete();
    cyc = 0;
    @(negedge clk);
    rst = 1'b0;
    check_outputs();
  endtask

  initial begin
    // Reset values and release
    @(negedge clk);
    chk_an("rst_an", 4'hF);
    chk_seg("rst_seg", 7'h7F);
    chk_rdy("rst_rdy", 1'b1);
    rst = 1'b0;
    cyc = 0;
    check_outputs();

    // First frame: guard cycles, then anodes walk E, D, B, 7
    for (int i = 0; i < FRAME; i++) begin
      step(1'b0, 16'h0, 1'b1);
      if (cyc == 1) chk_an("first_blank", 4'hF);
      if ((cyc % RD) == BC) chk_an("an_walk", an_seq[(cyc / RD) % ND]);
      if ((cyc % RD) >= BC && ((cyc / RD) % ND) == 0) chk_seg("digit0_zero", 7'b0000001);
    end

    // Mid-frame write held off until the frame boundary
    go_to(13);
    write_word(16'h12AF);
    while ((cyc % FRAME) != 0) begin
      chk_rdy("pending_rdy", 1'b0);
      step(1'b0, 16'($urandom), 1'b1);
    end
    chk_rdy("rdy_after_wrap", 1'b1);
    go_to(2);
    chk_seg("digit0_F", 7'b0111000);
    go_to(10);
    chk_seg("digit1_A", 7'b0001000);

    // Second write stalls while pending and lands one frame later
    go_to(5);
    write_word(16'h3456);
    write_word(16'h789B);
    go_to(2);
    chk_seg("first_of_two", 7'b0100000);
    chk_rdy("second_pending", 1'b0);
    go_to(0);
    go_to(2);
    chk_seg("second_of_two", 7'b1100000);

    // Write accepted on the boundary edge waits for the following boundary
    go_to(31);
    step(1'b1, 16'hC0DE, 1'b1);
    go_to(2);
    chk_seg("boundary_old", 7'b1100000);
    chk_rdy("boundary_pending", 1'b0);
    go_to(0);
    go_to(2);
    chk_seg("boundary_new", 7'b0110000);

    // en dropped mid-drive, restored mid-slot
    go_to(4);
    chk_an("en_on", 4'hE);
    step(1'b0, 16'h0, 1'b0);
    chk_an("en_off", 4'hF);
    while ((cyc % FRAME) != 12) step(1'b0, 16'($urandom), 1'b0);
    step(1'b0, 16'h0, 1'b1);
    chk_an("en_back", 4'hD);

    // Random traffic against the model
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 3) == 0), 16'($urandom), ($urandom_range(0, 9) != 0));
    end

    // Small values: leading-zero handling
    settle();
    write_word(16'h0005);
    settle();
    go_to(2);
    chk_seg("val5_digit0", 7'b0100100);
    go_to(10);
    chk_an("val5_digit1_an", 4'hD);
`ifdef SEG7_LZ_BLANK_EN
    chk_seg("val5_digit1", 7'h7F);
`else
    chk_seg("val5_digit1", 7'b0000001);
`endif
    write_word(16'h0000);
    settle();
    go_to(2);
    chk_seg("val0_digit0", 7'b0000001);

    // Reset while a write is pending discards it
    write_word(16'hBEEF);
    step(1'b0, 16'h0, 1'b1);
    step(1'b0, 16'h0, 1'b1);
    pulse_reset();
    go_to(2);
    chk_seg("post_rst_d0", 7'b0000001);
    chk_rdy("post_rst_rdy", 1'b1);
    go_to(26);
`ifdef SEG7_LZ_BLANK_EN
    chk_seg("post_rst_d3", 7'h7F);
`else
    chk_seg("post_rst_d3", 7'b0000001);
`endif
    go_to(0);
    go_to(2);
    chk_seg("post_rst_frame2", 7'b0000001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg7_scan_ctrl.md
SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed hex digits (range 1..8).
REQ-002 SHALL have parameter REFRESH_DIV, default 50000, clock cycles per digit slot (at least 4).
REQ-003 SHALL have parameter BLANK_CYCLES, default 16, anode-off guard cycles at the start of each slot (1..REFRESH_DIV-2).
REQ-004 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port en, input, 1, display enable; low forces all anodes off.
REQ-007 SHALL have port wr_valid, input, 1, new display value offered.
REQ-008 SHALL have port wr_ready, output, 1, write accepted when wr_valid and wr_ready are both high.
REQ-009 SHALL have port wr_data, input, 4*NUM_DIGITS, nibble k drives digit k; digit 0 is rightmost.
REQ-010 SHALL have port seg_n, output, 7, active-low segments {a,b,c,d,e,f,g}, with seg_n[6]=a.
REQ-011 SHALL have port an_n, output, NUM_DIGITS, active-low digit anodes; at most one bit low.

Function
REQ-012 SHALL run tick_cnt 0..REFRESH_DIV-1, wrapping; on wrap, digit_idx increments modulo NUM_DIGITS.
REQ-013 SHALL use a two-state FSM: BLANK while tick_cnt < BLANK_CYCLES, DRIVE otherwise.
- BLANK: an_n all ones, seg_n = 7'h7F.
- DRIVE: an_n bit digit_idx low only if en=1; seg_n holds the hex code of nibble digit_idx of disp_reg.
REQ-014 SHALL decode hex as standard active-low patterns:
- 0 = 7'b0000001
- 1 = 7'b1001111
- 8 = 7'b0000000
- A = 7'b0001000
- F = 7'b0111000
REQ-015 SHALL register seg_n and an_n, changing on the same edge the FSM state or digit_idx changes.
REQ-016 SHALL drive wr_ready = ~pending.
- An accepted write loads shadow_reg and sets pending on the next edge.
REQ-017 SHALL copy shadow_reg into disp_reg and clear pending on the edge where digit_idx wraps to 0 (frame boundary), so no frame is torn.
REQ-018 SHALL apply a write accepted on the frame-boundary edge itself at the following boundary, not the current one.
REQ-019 SHALL keep wr_ready low while pending is set, so a second write is stalled and not dropped.
REQ-020 SHALL, when en deasserts mid-DRIVE, force an_n all ones on the next edge while counters keep running.

Reset
REQ-021 SHALL, while rst is high, asynchronously clear the following:
- tick_cnt=0, digit_idx=0, state=BLANK
- disp_reg=0, shadow_reg=0, pending=0
- an_n all ones, seg_n=7'h7F
- wr_ready=1
REQ-022 SHALL discard any pending write when reset occurs mid-frame.

Configuration
REQ-023 SHALL support macro SEG7_LZ_BLANK_EN.
- Defined: in DRIVE, digits above the highest nonzero nibble show seg_n=7'h7F; digit 0 is never suppressed (value 0 shows "0").
- Undefined: all digits are always shown.

Structure
REQ-024 SHALL place the following in shared package seg7_pkg:
- hex-to-segment code constants
- SEG_BLANK = 7'h7F
- the FSM state typedef
REQ-025 SHALL use one sub-module, seg7_hex_dec: combinational 4-bit to 7-bit active-low decoder, instantiated once on the selected nibble.

Verification (NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2)
REQ-026 SHALL check release from reset with en=1:
- an_n=4'hF for cycles 0-1, then 4'hE for cycles 2-7.
- seg_n=7'b0000001 while digit 0 is driven.
- After 32 cycles, an_n has cycled E, D, B, 7.
REQ-027 SHALL check a write of 16'h12AF accepted mid-frame:
- wr_ready=0 until the next digit_idx wrap.
- Then digit 0 shows 7'b0111000 and digit 1 shows 7'b0001000.
REQ-028 SHALL check a second wr_valid while pending: it is held off by wr_ready=0 and applied one frame after the first.
REQ-029 SHALL check en toggled 1->0 during DRIVE: an_n=4'hF on the next edge, and the slot timing is unchanged when en returns.
REQ-030 SHALL check, with SEG7_LZ_BLANK_EN defined, that 16'h0005 shows only digit 0 as "5" and 16'h0000 shows digit 0 as "0".
REQ-031 SHALL check rst pulsed while pending: all outputs are at reset values and the old value never appears.
